// File: rtl/vgc_pkg.sv
// Shared constants for the VGC interrupt block: register addresses, bit positions
// and the scanout window.
package vgc_pkg;

    typedef enum logic [7:0] {
        ADDR_RDVBLBAR  = 8'h19,
        ADDR_VGCINT    = 8'h23,
        ADDR_SCANINT   = 8'h32,
        ADDR_INTEN     = 8'h41,
        ADDR_INTFLAG   = 8'h46,
        ADDR_CLRVBLINT = 8'h47
    } vgc_addr_e;

    localparam int VGCINT_PEND_BIT    = 7;
    localparam int VGCINT_SEC_ST_BIT  = 6;
    localparam int VGCINT_SCAN_ST_BIT = 5;
    localparam int VGCINT_SEC_EN_BIT  = 2;
    localparam int VGCINT_SCAN_EN_BIT = 1;

    localparam int SCANINT_SEC_BIT    = 6;
    localparam int SCANINT_SCAN_BIT   = 5;

    localparam int INTEN_QTR_BIT      = 4;
    localparam int INTEN_VBL_BIT      = 3;
    localparam int INTFLAG_QTR_BIT    = 4;
    localparam int INTFLAG_VBL_BIT    = 3;
    localparam int RDVBLBAR_BIT       = 7;

    localparam logic [9:0] SCAN_FIRST = 10'd256;
    localparam logic [9:0] SCAN_LAST  = 10'd455;

    localparam logic [5:0] CNT60_LAST = 6'd59;
    localparam int         QTR_PERIOD = 15;

    function automatic logic in_scan_window(input logic [9:0] v);
        return (v >= SCAN_FIRST) && (v <= SCAN_LAST);
    endfunction

endpackage

// File: rtl/vgc_tick_div.sv
// Divides VBL events by 60, producing quarter-second and one-second ticks
// combinationally alongside the VBL event that causes them.
module vgc_tick_div (
    input  logic clk_vid,
    input  logic reset_n,
    input  logic vbl_evt,
    output logic qtr_tick,
    output logic sec_tick
);
    import vgc_pkg::*;

    logic [5:0] cnt60_reg;
    logic [3:0] qtr_hit;

    always_ff @(posedge clk_vid or negedge reset_n) begin
        if (!reset_n) begin
            cnt60_reg <= '0;
        end else if (vbl_evt) begin
            cnt60_reg <= (cnt60_reg == CNT60_LAST) ? 6'd0 : cnt60_reg + 6'd1;
        end
    end

    // Quarter points are the last count of each 15-frame group: 14, 29, 44, 59.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_qtr
            assign qtr_hit[gi] = (cnt60_reg == 6'(QTR_PERIOD * (gi + 1) - 1));
        end
    endgenerate

    assign qtr_tick = vbl_evt & (|qtr_hit);
    assign sec_tick = vbl_evt & (cnt60_reg == CNT60_LAST);

endmodule

// File: rtl/vgc_irq.sv
// VGC interrupt controller: scanline / VBL / quarter- and one-second status flags,
// their enables, the $C0xx register file and the registered irq_n output.
module vgc_irq (
    input  logic       clk_vid,
    input  logic       reset_n,
    input  logic       ce_pix,
    input  logic       hblank,
    input  logic [9:0] vpos,
    input  logic       mega2_vbl,
    input  logic       scb_irq,
    input  logic       io_wr,
    input  logic       io_rd,
    input  logic [7:0] io_addr,
    input  logic [7:0] io_din,
    output logic [7:0] io_dout,
    output logic       irq_n
);
    import vgc_pkg::*;

    logic hblank_reg, vbl_reg, scb_reg;
    logic scan_evt, vbl_evt, qtr_tick, sec_tick;
    logic wr_vgcint, wr_scanint, wr_inten, wr_clrvbl;
    logic sec_st_reg, scan_st_reg, vbl_st_reg, qtr_st_reg;
    logic sec_en_reg, scan_en_reg;
    logic [4:0] inten_reg;
    logic vgc_pend, irq_any;

    // Inputs only move on ce_pix, so plain per-clock edge detection suffices.
    logic unused_ok;
    assign unused_ok = &{1'b0, ce_pix, io_rd};

    assign scan_evt = hblank & ~hblank_reg & scb_reg & in_scan_window(vpos);
    assign vbl_evt  = mega2_vbl & ~vbl_reg;

    vgc_tick_div u_tick_div (
        .clk_vid  (clk_vid),
        .reset_n  (reset_n),
        .vbl_evt  (vbl_evt),
        .qtr_tick (qtr_tick),
        .sec_tick (sec_tick)
    );

    assign wr_vgcint  = io_wr & (io_addr == ADDR_VGCINT);
    assign wr_scanint = io_wr & (io_addr == ADDR_SCANINT);
    assign wr_inten   = io_wr & (io_addr == ADDR_INTEN);
    assign wr_clrvbl  = io_wr & (io_addr == ADDR_CLRVBLINT);

    assign vgc_pend = (sec_st_reg & sec_en_reg) | (scan_st_reg & scan_en_reg);
    assign irq_any  = vgc_pend
                    | (vbl_st_reg & inten_reg[INTEN_VBL_BIT])
                    | (qtr_st_reg & inten_reg[INTEN_QTR_BIT]);

    always_ff @(posedge clk_vid or negedge reset_n) begin
        if (!reset_n) begin
            hblank_reg  <= 1'b0;
            vbl_reg     <= 1'b0;
            scb_reg     <= 1'b0;
            sec_st_reg  <= 1'b0;
            scan_st_reg <= 1'b0;
            vbl_st_reg  <= 1'b0;
            qtr_st_reg  <= 1'b0;
            sec_en_reg  <= 1'b0;
            scan_en_reg <= 1'b0;
            inten_reg   <= '0;
            irq_n       <= 1'b1;
        end else begin
            hblank_reg <= hblank;
            vbl_reg    <= mega2_vbl;
            scb_reg    <= scb_irq;

            // A set arriving in the same clock as a clear wins.
            scan_st_reg <= scan_evt | (scan_st_reg & ~(wr_scanint & ~io_din[SCANINT_SCAN_BIT]));
            sec_st_reg  <= sec_tick | (sec_st_reg & ~(wr_scanint & ~io_din[SCANINT_SEC_BIT]));
            vbl_st_reg  <= vbl_evt  | (vbl_st_reg & ~wr_clrvbl);
            qtr_st_reg  <= qtr_tick | (qtr_st_reg & ~wr_clrvbl);

            if (wr_vgcint) begin
                sec_en_reg  <= io_din[VGCINT_SEC_EN_BIT];
                scan_en_reg <= io_din[VGCINT_SCAN_EN_BIT];
            end
            if (wr_inten) begin
                inten_reg <= io_din[4:0];
            end

            irq_n <= ~irq_any;
        end
    end

    always_comb begin
        io_dout = 8'h00;
        case (io_addr)
            ADDR_VGCINT: begin
                io_dout[VGCINT_PEND_BIT]    = vgc_pend;
                io_dout[VGCINT_SEC_ST_BIT]  = sec_st_reg;
                io_dout[VGCINT_SCAN_ST_BIT] = scan_st_reg;
                io_dout[VGCINT_SEC_EN_BIT]  = sec_en_reg;
                io_dout[VGCINT_SCAN_EN_BIT] = scan_en_reg;
            end
            ADDR_INTEN: begin
                io_dout = {3'b000, inten_reg};
            end
            ADDR_INTFLAG: begin
                io_dout[INTFLAG_QTR_BIT] = qtr_st_reg;
                io_dout[INTFLAG_VBL_BIT] = vbl_st_reg;
            end
            ADDR_RDVBLBAR: begin
                io_dout[RDVBLBAR_BIT] = ~mega2_vbl;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_vgc_irq.sv
// Bench for vgc_irq: register table, directed multi-cycle scenarios and a
// randomized run against an event-counting reference model.
module tb_vgc_irq;

    logic       clk_vid = 1'b0;
    logic       reset_n;
    logic       ce_pix;
    logic       hblank;
    logic [9:0] vpos;
    logic       mega2_vbl;
    logic       scb_irq;
    logic       io_wr;
    logic       io_rd;
    logic [7:0] io_addr;
    logic [7:0] io_din;
    logic [7:0] io_dout;
    logic       irq_n;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk_vid = ~clk_vid;

    vgc_irq dut (
        .clk_vid   (clk_vid),
        .reset_n   (reset_n),
        .ce_pix    (ce_pix),
        .hblank    (hblank),
        .vpos      (vpos),
        .mega2_vbl (mega2_vbl),
        .scb_irq   (scb_irq),
        .io_wr     (io_wr),
        .io_rd     (io_rd),
        .io_addr   (io_addr),
        .io_din    (io_din),
        .io_dout   (io_dout),
        .irq_n     (irq_n)
    );

    // ---------------- reference model ----------------
    logic       m_scan_st, m_sec_st, m_vbl_st, m_qtr_st;
    logic       m_scan_en, m_sec_en;
    logic [4:0] m_inten;
    logic       m_irq_n;
    logic       m_prev_hb, m_prev_scb, m_prev_vbl;
    int         m_vbl_count;

    function automatic logic m_pend();
        return (m_sec_st && m_sec_en) || (m_scan_st && m_scan_en);
    endfunction

    function automatic logic [7:0] model_dout(input logic [7:0] a);
        case (a)
            8'h23:   return {m_pend(), m_sec_st, m_scan_st, 2'b00, m_sec_en, m_scan_en, 1'b0};
            8'h41:   return {3'b000, m_inten};
            8'h46:   return {3'b000, m_qtr_st, m_vbl_st, 3'b000};
            8'h19:   return {~mega2_vbl, 7'b0};
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_reset();
        m_scan_st = 0; m_sec_st = 0; m_vbl_st = 0; m_qtr_st = 0;
        m_scan_en = 0; m_sec_en = 0; m_inten = '0; m_irq_n = 1;
        m_prev_hb = 0; m_prev_scb = 0; m_prev_vbl = 0; m_vbl_count = 0;
    endtask

    // Advance the model across one clock edge using the currently driven inputs.
    task automatic model_edge();
        logic scan_evt, vbl_evt, qtr, sec, next_irq_n;
        next_irq_n = !(m_pend() || (m_vbl_st && m_inten[3]) || (m_qtr_st && m_inten[4]));
        scan_evt = hblank && !m_prev_hb && m_prev_scb && (vpos >= 10'd256) && (vpos <= 10'd455);
        vbl_evt  = mega2_vbl && !m_prev_vbl;
        qtr = 0;
        sec = 0;
        if (vbl_evt) begin
            m_vbl_count++;
            qtr = (m_vbl_count % 15) == 0;
            sec = (m_vbl_count % 60) == 0;
        end
        if (io_wr && io_addr == 8'h32) begin
            if (!io_din[6]) m_sec_st = 0;
            if (!io_din[5]) m_scan_st = 0;
        end
        if (io_wr && io_addr == 8'h47) begin
            m_vbl_st = 0;
            m_qtr_st = 0;
        end
        if (io_wr && io_addr == 8'h23) begin
            m_sec_en  = io_din[2];
            m_scan_en = io_din[1];
        end
        if (io_wr && io_addr == 8'h41) m_inten = io_din[4:0];
        if (scan_evt) m_scan_st = 1;
        if (sec)      m_sec_st  = 1;
        if (vbl_evt)  m_vbl_st  = 1;
        if (qtr)      m_qtr_st  = 1;
        m_irq_n    = next_irq_n;
        m_prev_hb  = hblank;
        m_prev_scb = scb_irq;
        m_prev_vbl = mega2_vbl;
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h, expected %02h", name, act, exp);
        end
    endtask

    task automatic check_irq(input string name, input logic exp);
        check(name, {7'b0, irq_n}, {7'b0, exp});
    endtask

    task automatic step();
        @(posedge clk_vid);
        #1;
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] exp, input string name);
        io_addr = a;
        io_rd   = 1'b1;
        #1;
        check(name, io_dout, exp);
        $display("rd %02h -> %02h (%s)", a, io_dout, name);
        io_rd = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        io_wr   = 1'b1;
        io_addr = a;
        io_din  = d;
        $display("wr %02h <= %02h", a, d);
        step();
        io_wr = 1'b0;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0; hblank = 1'b0; vpos = 10'd250; mega2_vbl = 1'b0;
        scb_irq = 1'b0; io_wr = 1'b0; io_rd = 1'b0; io_addr = 8'h00; io_din = 8'h00;
        model_reset();
        step();
        step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic vbl_pulse();
        mega2_vbl = 1'b1;
        step();
        mega2_vbl = 1'b0;
        step();
    endtask

    // Leaves hblank high, sampled just after the edge that detects the rise.
    task automatic line_rise(input logic [9:0] v, input logic s);
        hblank  = 1'b0;
        vpos    = v;
        scb_irq = s;
        step();
        step();
        hblank = 1'b1;
        step();
    endtask

    function automatic logic [9:0] pick_vpos();
        int r;
        r = $urandom_range(7);
        case (r)
            0:       return 10'd255;
            1:       return 10'd256;
            2:       return 10'd455;
            3:       return 10'd456;
            default: return 10'($urandom_range(511, 250));
        endcase
    endfunction

    typedef struct {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] din;
        logic       vbl;
        logic [7:0] dout;
        logic       irq_n;
    } vec_t;

    vec_t tbl[19];
    logic [7:0] wr_addrs[4];
    logic [7:0] rd_addrs[7];

    initial begin
        tbl[0]  = '{1'b0, 8'h23, 8'h00, 1'b0, 8'h00, 1'b1};
        tbl[1]  = '{1'b0, 8'h41, 8'h00, 1'b0, 8'h00, 1'b1};
        tbl[2]  = '{1'b0, 8'h46, 8'h00, 1'b0, 8'h00, 1'b1};
        tbl[3]  = '{1'b0, 8'h19, 8'h00, 1'b0, 8'h80, 1'b1};
        tbl[4]  = '{1'b0, 8'h55, 8'h00, 1'b0, 8'h00, 1'b1};
        tbl[5]  = '{1'b1, 8'h41, 8'hE5, 1'b0, 8'h00, 1'b1};
        tbl[6]  = '{1'b0, 8'h41, 8'h00, 1'b0, 8'h05, 1'b1};
        tbl[7]  = '{1'b1, 8'h23, 8'hFF, 1'b0, 8'h00, 1'b1};
        tbl[8]  = '{1'b0, 8'h23, 8'h00, 1'b0, 8'h06, 1'b1};
        tbl[9]  = '{1'b1, 8'h23, 8'h00, 1'b0, 8'h06, 1'b1};
        tbl[10] = '{1'b0, 8'h23, 8'h00, 1'b0, 8'h00, 1'b1};
        tbl[11] = '{1'b0, 8'h19, 8'h00, 1'b1, 8'h00, 1'b1};
        tbl[12] = '{1'b0, 8'h46, 8'h00, 1'b1, 8'h08, 1'b1};
        tbl[13] = '{1'b1, 8'h41, 8'h08, 1'b0, 8'h05, 1'b1};
        tbl[14] = '{1'b0, 8'h46, 8'h00, 1'b0, 8'h08, 1'b1};
        tbl[15] = '{1'b0, 8'h41, 8'h00, 1'b0, 8'h08, 1'b0};
        tbl[16] = '{1'b1, 8'h47, 8'h00, 1'b0, 8'h00, 1'b0};
        tbl[17] = '{1'b0, 8'h46, 8'h00, 1'b0, 8'h00, 1'b0};
        tbl[18] = '{1'b0, 8'h46, 8'h00, 1'b0, 8'h00, 1'b1};
        wr_addrs = '{8'h23, 8'h32, 8'h41, 8'h47};
        rd_addrs = '{8'h19, 8'h23, 8'h32, 8'h41, 8'h46, 8'h47, 8'h00};

        ce_pix = 1'b1;
        apply_reset();
        reset_n = 1'b0;
        #1;
        check_irq("reset_irq_n", 1'b1);
        rd(8'h23, 8'h00, "reset_vgcint");
        reset_n = 1'b1;
        step();

        // ---- register table ----
        for (int i = 0; i < 19; i++) begin
            io_wr     = tbl[i].wr;
            io_rd     = !tbl[i].wr;
            io_addr   = tbl[i].addr;
            io_din    = tbl[i].din;
            mega2_vbl = tbl[i].vbl;
            #1;
            check($sformatf("tbl%0d_dout", i), io_dout, tbl[i].dout);
            check_irq($sformatf("tbl%0d_irq", i), tbl[i].irq_n);
            $display("vec %0d: wr=%0b addr=%02h din=%02h vbl=%0b -> dout=%02h irq_n=%0b",
                     i, tbl[i].wr, tbl[i].addr, tbl[i].din, tbl[i].vbl, io_dout, irq_n);
            step();
            io_wr = 1'b0;
            io_rd = 1'b0;
        end

        // ---- scanline interrupt ----
        apply_reset();
        wr(8'h23, 8'h02);
        line_rise(10'd299, 1'b0);
        rd(8'h23, 8'h02, "scan_no_scb");
        line_rise(10'd300, 1'b1);
        rd(8'h23, 8'hA2, "scan_set");
        check_irq("scan_irq_lat1", 1'b1);
        step();
        check_irq("scan_irq_lat2", 1'b0);
        hblank  = 1'b0;
        scb_irq = 1'b0;
        wr(8'h32, 8'hDF);
        rd(8'h23, 8'h02, "scan_clr");
        step();
        check_irq("scan_irq_release", 1'b1);

        // ---- one-second tick ----
        apply_reset();
        wr(8'h23, 8'h04);
        vbl_pulse();
        rd(8'h46, 8'h08, "sec_vbl_st_first");
        rd(8'h23, 8'h04, "sec_not_first");
        for (int i = 2; i < 60; i++) begin
            vbl_pulse();
            check_irq($sformatf("sec_irq_idle_%0d", i), 1'b1);
        end
        rd(8'h23, 8'h04, "sec_not_59");
        vbl_pulse();
        rd(8'h23, 8'hC4, "sec_at_60");
        check_irq("sec_irq", 1'b0);

        // ---- quarter-second tick ----
        apply_reset();
        wr(8'h41, 8'h10);
        for (int i = 0; i < 14; i++) vbl_pulse();
        rd(8'h46, 8'h08, "qtr_not_14");
        check_irq("qtr_irq_idle", 1'b1);
        vbl_pulse();
        rd(8'h46, 8'h18, "qtr_at_15");
        check_irq("qtr_irq", 1'b0);
        wr(8'h47, 8'h00);
        rd(8'h46, 8'h00, "qtr_clr");
        check_irq("qtr_irq_lat", 1'b0);
        step();
        check_irq("qtr_irq_release", 1'b1);

        // ---- set/clear collision ----
        apply_reset();
        vpos    = 10'd350;
        scb_irq = 1'b1;
        step();
        step();
        hblank  = 1'b1;
        io_wr   = 1'b1;
        io_addr = 8'h32;
        io_din  = 8'h00;
        step();
        io_wr = 1'b0;
        rd(8'h23, 8'h20, "collision_set_wins");

        // ---- reset mid-count ----
        apply_reset();
        wr(8'h23, 8'h04);
        for (int i = 0; i < 30; i++) vbl_pulse();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();
        rd(8'h23, 8'h00, "midreset_cleared");
        wr(8'h23, 8'h04);
        for (int i = 0; i < 59; i++) vbl_pulse();
        rd(8'h23, 8'h04, "midreset_59");
        vbl_pulse();
        rd(8'h23, 8'hC4, "midreset_60");

        // ---- scan window boundaries and RDVBLBAR ----
        apply_reset();
        line_rise(10'd456, 1'b1);
        rd(8'h23, 8'h00, "win_456");
        line_rise(10'd255, 1'b1);
        rd(8'h23, 8'h00, "win_255");
        line_rise(10'd511, 1'b1);
        rd(8'h23, 8'h00, "win_511");
        line_rise(10'd455, 1'b1);
        rd(8'h23, 8'h20, "win_455");
        wr(8'h32, 8'h00);
        rd(8'h23, 8'h00, "win_clr");
        line_rise(10'd256, 1'b1);
        rd(8'h23, 8'h20, "win_256");
        hblank    = 1'b0;
        mega2_vbl = 1'b1;
        rd(8'h19, 8'h00, "vblbar_high");
        mega2_vbl = 1'b0;
        rd(8'h19, 8'h80, "vblbar_low");

        // ---- randomized run against the model ----
        apply_reset();
        for (int c = 0; c < 4000; c++) begin
            io_wr = 1'b0;
            if (c == 2000) begin
                reset_n = 1'b0;
                model_reset();
            end
            if (c == 2003) reset_n = 1'b1;
            if ($urandom_range(2) == 0) hblank = ~hblank;
            else if (hblank) vpos = pick_vpos();
            scb_irq = ($urandom_range(3) != 0);
            if ($urandom_range(2) == 0) mega2_vbl = ~mega2_vbl;
            if ($urandom_range(15) == 0) begin
                io_wr   = 1'b1;
                io_addr = wr_addrs[$urandom_range(3)];
                io_din  = 8'($urandom);
                io_rd   = 1'b0;
                $display("rnd %0d: wr %02h <= %02h", c, io_addr, io_din);
            end else begin
                io_rd   = 1'b1;
                io_addr = rd_addrs[$urandom_range(6)];
                if (io_addr == 8'h00) io_addr = 8'($urandom);
            end
            #1;
            check($sformatf("rnd%0d_dout@%02h", c, io_addr), io_dout, model_dout(io_addr));
            check_irq($sformatf("rnd%0d_irq", c), m_irq_n);
            if (reset_n) model_edge();
            step();
        end
        io_wr = 1'b0;
        io_rd = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
